// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response port between the fetch stage and imem.
// The fetch unit is the master; memory drives rdata/valid.
interface if_fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_valid;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage with integrated IF/ID register: owns the PC, fetches over a
// req/valid memory port of arbitrary latency, honours freeze and branch redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [31:0]         branch_addr,
  if_fetch_unit_if.master     imem,
  output logic [31:0]         PC_out,
  output logic [31:0]         instruction,
  output logic                valid
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] redir_pc, redir_n;
  logic [XLEN-1:0] skid, skid_n;
  logic [XLEN-1:0] pc_out_n, instr_n, issue_word, pc_inc;
  logic            valid_n, req_q, bubble, issue;

  assign pc_inc         = pc + PC_STEP;
  assign imem.imem_req  = req_q;
  // pc only moves on a completed response or a redirect, so the address stays put mid-request
  assign imem.imem_addr = pc;

  // State and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redir_pc    <= RESET_PC;
      skid        <= '0;
      PC_out      <= '0;
      instruction <= BUBBLE_INSTR;
      valid       <= 1'b0;
      req_q       <= 1'b1;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      redir_pc    <= redir_n;
      skid        <= skid_n;
      PC_out      <= pc_out_n;
      instruction <= instr_n;
      valid       <= valid_n;
      req_q       <= (state_n != HOLD);
    end
  end

  // Next-state and IF/ID write selection; priority branch > freeze > imem_valid
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    redir_n    = redir_pc;
    skid_n     = skid;
    pc_out_n   = PC_out;
    instr_n    = instruction;
    valid_n    = valid;
    bubble     = 1'b0;
    issue      = 1'b0;
    issue_word = imem.imem_rdata;

    case (state)
      FETCH: begin
        if (branch_taken) begin
          bubble = 1'b1;
          if (imem.imem_valid) begin
            pc_n = branch_addr;
          end else begin
            redir_n = branch_addr;
            state_n = REDIRECT;
          end
        end else if (imem.imem_valid) begin
          if (freeze) begin
            skid_n  = imem.imem_rdata;
            state_n = HOLD;
          end else begin
            issue = 1'b1;
          end
        end else if (!freeze) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          bubble  = 1'b1;
          pc_n    = branch_addr;
          state_n = FETCH;
        end else if (!freeze) begin
          issue      = 1'b1;
          issue_word = skid;
          state_n    = FETCH;
        end
      end
      REDIRECT: begin
        // Waiting out the stale request; the latest redirect target wins
        bubble = 1'b1;
        if (branch_taken) begin
          redir_n = branch_addr;
        end
        if (imem.imem_valid) begin
          pc_n    = branch_taken ? branch_addr : redir_pc;
          state_n = FETCH;
        end
      end
      default: begin
        bubble  = 1'b1;
        state_n = FETCH;
      end
    endcase

    if (bubble) begin
      pc_out_n = '0;
      instr_n  = BUBBLE_INSTR;
      valid_n  = 1'b0;
    end
    if (issue) begin
      pc_out_n = pc_inc;
      instr_n  = issue_word;
      valid_n  = 1'b1;
      pc_n     = pc_inc;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against an
// in-order instruction-stream reference model and a variable-latency memory.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_addr, PC_out, instruction;
  logic        valid;
  int unsigned lat;
  int unsigned wait_cnt;
  int          tests_run = 0;
  int          failed = 0;

  if_fetch_unit_if mif ();

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem(mif), .PC_out(PC_out),
    .instruction(instruction), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Memory: responds once a request has waited lat cycles (lat=0 -> same cycle)
  always_ff @(posedge clk) begin
    if (rst) wait_cnt <= 0;
    else if (mif.imem_req && !mif.imem_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always_comb begin
    mif.imem_valid = mif.imem_req && (wait_cnt >= lat);
    mif.imem_rdata = mif.imem_valid ? mem_word(mif.imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h1234_5670; lat = 0;
    tick(); tick();
    tests_run++;
    if ({valid, PC_out, instruction} !== {1'b0, 32'h0, BUBBLE_INSTR}) begin
      failed++; $display("FAIL reset_outputs: got v=%0b pc=%h ins=%h, want v=0 pc=0 ins=%h", valid, PC_out, instruction, BUBBLE_INSTR);
    end
    tests_run++;
    if ({mif.imem_req, mif.imem_addr} !== {1'b1, RESET_PC}) begin
      failed++; $display("FAIL reset_fetch: got req=%0b addr=%h, want req=1 addr=%h", mif.imem_req, mif.imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    lat = 0; do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if ({valid, PC_out, instruction} !== {1'b1, 32'(4*(i+1)), mem_word(32'(4*i))}) begin
        failed++; $display("FAIL seq_%0d: got v=%0b pc=%h ins=%h, want v=1 pc=%h ins=%h", i, valid, PC_out, instruction, 32'(4*(i+1)), mem_word(32'(4*i)));
      end
    end
  endtask

  task automatic test_freeze();
    lat = 0; do_reset();
    tick(); tick();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({valid, PC_out, instruction, mif.imem_req} !== {1'b1, 32'd8, mem_word(32'd4), 1'b0}) begin
        failed++; $display("FAIL freeze_hold_%0d: got v=%0b pc=%h ins=%h req=%0b, want v=1 pc=8 ins=%h req=0", i, valid, PC_out, instruction, mif.imem_req, mem_word(32'd4));
      end
    end
    freeze = 1'b0;
    tick();
    tests_run++;
    if ({valid, PC_out, instruction} !== {1'b1, 32'd12, mem_word(32'd8)}) begin
      failed++; $display("FAIL freeze_release: got v=%0b pc=%h ins=%h, want v=1 pc=c ins=%h", valid, PC_out, instruction, mem_word(32'd8));
    end
    tick();
    tests_run++;
    if ({valid, PC_out, instruction} !== {1'b1, 32'd16, mem_word(32'd12)}) begin
      failed++; $display("FAIL freeze_next: got v=%0b pc=%h ins=%h, want v=1 pc=10 ins=%h", valid, PC_out, instruction, mem_word(32'd12));
    end
  endtask

  task automatic test_redirect();
    int n;
    lat = 2; do_reset();
    branch_taken = 1'b1; branch_addr = 32'h40;
    tick();
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({valid, mif.imem_req, mif.imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
        failed++; $display("FAIL redirect_wait_%0d: got v=%0b req=%0b addr=%h, want v=0 req=1 addr=0", i, valid, mif.imem_req, mif.imem_addr);
      end
      tick();
    end
    tests_run++;
    if ({valid, mif.imem_addr} !== {1'b0, 32'h40}) begin
      failed++; $display("FAIL redirect_target: got v=%0b addr=%h, want v=0 addr=40", valid, mif.imem_addr);
    end
    n = 0;
    do begin tick(); n++; end while (valid !== 1'b1 && n < 10);
    tests_run++;
    if ({n[7:0], valid, PC_out, instruction} !== {8'd3, 1'b1, 32'h44, mem_word(32'h40)}) begin
      failed++; $display("FAIL redirect_issue: got cycles=%0d v=%0b pc=%h ins=%h, want cycles=3 v=1 pc=44 ins=%h", n, valid, PC_out, instruction, mem_word(32'h40));
    end
  endtask

  task automatic test_hold_branch();
    lat = 0; do_reset();
    tick();
    freeze = 1'b1;
    tick();
    tests_run++;
    if ({mif.imem_req, valid, PC_out} !== {1'b0, 1'b1, 32'd4}) begin
      failed++; $display("FAIL hold_entry: got req=%0b v=%0b pc=%h, want req=0 v=1 pc=4", mif.imem_req, valid, PC_out);
    end
    branch_taken = 1'b1; branch_addr = 32'h100;
    tick();
    tests_run++;
    if ({valid, PC_out, instruction, mif.imem_req, mif.imem_addr} !== {1'b0, 32'h0, BUBBLE_INSTR, 1'b1, 32'h100}) begin
      failed++; $display("FAIL hold_branch: got v=%0b pc=%h ins=%h req=%0b addr=%h, want v=0 pc=0 ins=%h req=1 addr=100", valid, PC_out, instruction, mif.imem_req, mif.imem_addr, BUBBLE_INSTR);
    end
    branch_taken = 1'b0; freeze = 1'b0;
    tick();
    tests_run++;
    if ({valid, PC_out, instruction} !== {1'b1, 32'h104, mem_word(32'h100)}) begin
      failed++; $display("FAIL hold_branch_issue: got v=%0b pc=%h ins=%h, want v=1 pc=104 ins=%h", valid, PC_out, instruction, mem_word(32'h100));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    lat = 0; do_reset();
    tick(); tick();
    lat = 3;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({valid, PC_out, mif.imem_req, mif.imem_addr} !== {1'b0, 32'h0, 1'b1, RESET_PC}) begin
      failed++; $display("FAIL reset_mid: got v=%0b pc=%h req=%0b addr=%h, want v=0 pc=0 req=1 addr=%h", valid, PC_out, mif.imem_req, mif.imem_addr, RESET_PC);
    end
    n = 0;
    do begin tick(); n++; end while (valid !== 1'b1 && n < 12);
    tests_run++;
    if ({n[7:0], PC_out, instruction} !== {8'd4, 32'd4, mem_word(RESET_PC)}) begin
      failed++; $display("FAIL reset_mid_refetch: got cycles=%0d pc=%h ins=%h, want cycles=4 pc=4 ins=%h", n, PC_out, instruction, mem_word(RESET_PC));
    end
  endtask

  task automatic test_wrap();
    lat = 0; do_reset();
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tests_run++;
    if ({valid, mif.imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
      failed++; $display("FAIL wrap_setup: got v=%0b addr=%h, want v=0 addr=fffffffc", valid, mif.imem_addr);
    end
    tick();
    tests_run++;
    if ({valid, PC_out, instruction, mif.imem_addr} !== {1'b1, 32'h0, mem_word(32'hFFFF_FFFC), 32'h0}) begin
      failed++; $display("FAIL wrap_issue: got v=%0b pc=%h ins=%h addr=%h, want v=1 pc=0 ins=%h addr=0", valid, PC_out, instruction, mif.imem_addr, mem_word(32'hFFFF_FFFC));
    end
    tick();
    tests_run++;
    if ({valid, PC_out, instruction} !== {1'b1, 32'd4, mem_word(32'h0)}) begin
      failed++; $display("FAIL wrap_next: got v=%0b pc=%h ins=%h, want v=1 pc=4 ins=%h", valid, PC_out, instruction, mem_word(32'h0));
    end
  endtask

  // Reference: the instruction stream is in-order from the latest redirect target;
  // a frozen edge leaves the IF/ID register untouched.
  task automatic test_random();
    logic [31:0] exp_pc, prev_out, prev_ins, addr_pre, ba;
    logic        prev_v, req_pre, vld_pre, fr, br;
    int          issued = 0;
    lat = 0; do_reset();
    exp_pc = RESET_PC;
    prev_out = PC_out; prev_ins = instruction; prev_v = valid;
    for (int c = 0; c < 3000; c++) begin
      fr = ($urandom_range(0, 99) < 30);
      br = ($urandom_range(0, 99) < 8);
      ba = $urandom & 32'hFFFF_FFFC;
      freeze = fr; branch_taken = br; branch_addr = ba;
      lat = $urandom_range(0, 3);
      @(negedge clk);
      req_pre = mif.imem_req; vld_pre = mif.imem_valid; addr_pre = mif.imem_addr;
      tick();
      if (br) exp_pc = ba;
      tests_run++;
      if (fr && !br) begin
        if ({valid, PC_out, instruction} !== {prev_v, prev_out, prev_ins}) begin
          failed++; $display("FAIL rand_freeze c=%0d: got v=%0b pc=%h ins=%h, want v=%0b pc=%h ins=%h", c, valid, PC_out, instruction, prev_v, prev_out, prev_ins);
        end
      end else if (valid === 1'b1) begin
        if ({PC_out, instruction} !== {exp_pc + 32'd4, mem_word(exp_pc)}) begin
          failed++; $display("FAIL rand_issue c=%0d: got pc=%h ins=%h, want pc=%h ins=%h", c, PC_out, instruction, exp_pc + 32'd4, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        issued++;
      end else if ({valid, PC_out, instruction} !== {1'b0, 32'h0, BUBBLE_INSTR}) begin
        failed++; $display("FAIL rand_bubble c=%0d: got v=%0b pc=%h ins=%h, want v=0 pc=0 ins=%h", c, valid, PC_out, instruction, BUBBLE_INSTR);
      end
      if (req_pre && !vld_pre) begin
        tests_run++;
        if (mif.imem_addr !== addr_pre) begin
          failed++; $display("FAIL rand_addr_stable c=%0d: got addr=%h, want %h", c, mif.imem_addr, addr_pre);
        end
      end
      prev_out = PC_out; prev_ins = instruction; prev_v = valid;
    end
    freeze = 1'b0; branch_taken = 1'b0;
    tests_run++;
    if (issued < 100) begin
      failed++; $display("FAIL rand_progress: got %0d issued, want at least 100", issued);
    end
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; lat = 0;
    test_reset();
    test_sequential();
    test_freeze();
    test_redirect();
    test_hold_branch();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
